// File: rtl/checker_pkg.sv
// checker_pkg: shared verdict codes and checker states
package checker_pkg;
  typedef enum logic [2:0] {
    NONE,
    DATA_MISMATCH,
    UNEXPECTED_ADDR,
    ORDER,
    DUPLICATE,
    TIMEOUT
  } fail_e;
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} chk_state_e;
endpackage

// File: rtl/store_match_table.sv
// store_match_table: combinational lookup of a store against the expected (addr,data) table
module store_match_table #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int N_EXP = 1,
  parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = 20'h80064,
  parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = 32'd25,
  localparam int CW = $clog2(N_EXP + 1)
) (
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data,
  input  logic [N_EXP-1:0]  seen,
  input  logic [CW-1:0]     idx,
  input  logic              strict,
  output logic              hit,
  output logic [CW-1:0]     hit_idx,
  output logic              addr_hit,
  output logic              later_hit,
  output logic              dup_hit
);
  // walk the table from the top so the lowest matching entry wins in any-order mode
  always_comb begin
    hit = 1'b0;
    hit_idx = idx;
    addr_hit = 1'b0;
    later_hit = 1'b0;
    dup_hit = 1'b0;
    for (int i = N_EXP - 1; i >= 0; i--) begin
      if (strict) begin
        if (CW'(i) == idx) begin
          hit = adr == EXP_ADDR[i*ADDR_W +: ADDR_W] && data == EXP_DATA[i*DATA_W +: DATA_W];
          addr_hit = adr == EXP_ADDR[i*ADDR_W +: ADDR_W] && data != EXP_DATA[i*DATA_W +: DATA_W];
        end
        if (CW'(i) > idx && adr == EXP_ADDR[i*ADDR_W +: ADDR_W]) later_hit = 1'b1;
      end else begin
        if (adr == EXP_ADDR[i*ADDR_W +: ADDR_W] && data == EXP_DATA[i*DATA_W +: DATA_W] && !seen[i]) begin
          hit = 1'b1;
          hit_idx = CW'(i);
        end
        if (adr == EXP_ADDR[i*ADDR_W +: ADDR_W] && data != EXP_DATA[i*DATA_W +: DATA_W]) addr_hit = 1'b1;
        if (adr == EXP_ADDR[i*ADDR_W +: ADDR_W] && data == EXP_DATA[i*DATA_W +: DATA_W] && seen[i]) dup_hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/store_checker.sv
// store_checker: store-bus monitor producing a sticky PASS/FAIL verdict with fail code and timeout
module store_checker #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int N_EXP = 1,
  parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = 20'h80064,
  parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = 32'd25,
  parameter logic [ADDR_W-1:0] IGN_ADDR = 20'h80060,
  parameter logic [ADDR_W-1:0] IGN_MASK = 20'hFFFFC,
  parameter bit STRICT_ORDER = 1'b1,
  parameter int TIMEOUT = 1000,
  localparam int CW = $clog2(N_EXP + 1),
  localparam int CNT_W = $clog2(TIMEOUT + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] mem_adr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [2:0]        fail_code,
  output logic [CW-1:0]     match_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [15:0]       load_cnt
);
  import checker_pkg::*;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  chk_state_e state, state_n;
  fail_e code, code_n, viol_code;
  logic [CW-1:0] match_n, hit_idx;
  logic [N_EXP-1:0] seen, seen_n;
  logic hit, addr_hit, later_hit, dup_hit, ign, viol;
  store_match_table #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_EXP(N_EXP), .EXP_ADDR(EXP_ADDR), .EXP_DATA(EXP_DATA)
  ) u_tab (
    .adr(mem_adr), .data(mem_wdata), .seen(seen), .idx(match_cnt), .strict(STRICT_ORDER),
    .hit(hit), .hit_idx(hit_idx), .addr_hit(addr_hit), .later_hit(later_hit), .dup_hit(dup_hit)
  );
  assign ign = (mem_adr & IGN_MASK) == (IGN_ADDR & IGN_MASK);
  // classify a non-matching store; table hits outrank the ignore window
  always_comb begin
    viol_code = addr_hit ? DATA_MISMATCH : dup_hit ? DUPLICATE : later_hit ? ORDER : ign ? NONE : UNEXPECTED_ADDR;
    viol = mem_write && !hit && viol_code != NONE;
  end
  // next state: store verdict first, timeout only if the store left us in RUN
  always_comb begin
    state_n = state;
    code_n = code;
    match_n = match_cnt;
    seen_n = seen;
    if (state == IDLE) state_n = RUN;
    else if (state == RUN) begin
      if (mem_write && hit) begin
        match_n = match_cnt + 1'b1;
        seen_n = STRICT_ORDER ? seen : seen | (N_EXP'(1) << hit_idx);
        if (match_n == CW'(N_EXP)) state_n = PASS;
      end else if (viol) begin
        state_n = FAIL;
        code_n = viol_code;
      end
      if (state_n == RUN && TIMEOUT != 0 && cycle_cnt == TO_LAST) begin
        state_n = FAIL;
        code_n = checker_pkg::TIMEOUT;
      end
    end
  end
  // state, verdict, seen-bitmap and saturating RUN counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      code <= NONE;
      match_cnt <= '0;
      seen <= '0;
      cycle_cnt <= '0;
      load_cnt <= '0;
    end else begin
      state <= state_n;
      code <= code_n;
      match_cnt <= match_n;
      seen <= seen_n;
      if (state == RUN) begin
        if (~&cycle_cnt) cycle_cnt <= cycle_cnt + 1'b1;
        if (mem_read && ~&load_cnt) load_cnt <= load_cnt + 1'b1;
      end
    end
  end
  assign pass = state == PASS;
  assign fail = state == FAIL;
  assign done = pass | fail;
  assign fail_code = code;
endmodule
